apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_master_if.sv | 45 ++++
 rtl/apb_master_wdog.sv | 37 +++
 rtl/apb_master.sv | 99 +++++++++
 tb/tb_apb_master.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// apb_pkg -- shared definitions for the APB requester.
//   apb_state_e        : requester FSM states (IDLE / SETUP / ACCESS)
//   APB_ADDR_WIDTH     : default PADDR / req_addr width
//   APB_DATA_WIDTH     : default PWDATA / PRDATA / req_wdata / rsp_rdata width
//   APB_TIMEOUT_CYCLES : default ACCESS-cycle limit while waiting for PREADY
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_ADDR_WIDTH     = 32;
  localparam int APB_DATA_WIDTH     = 32;
  localparam int APB_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/apb_master_if.sv
// apb_master_if -- host request/response handshake plus APB requester bus.
//
// Handshake semantics: a request transfers on a rising PCLK edge where
// req_valid and req_ready are both high; req_write/req_addr/req_wdata are
// sampled on that edge. rsp_valid is a one-cycle pulse with no back-pressure;
// rsp_rdata and rsp_err are meaningful only while rsp_valid is high.
//
// Modports:
//   master : the requester (apb_master) view
//   slave  : the host + APB completer view (environment side)
interface apb_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // host request
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  // host response
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  // APB bus
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master_wdog.sv
// apb_master_wdog -- ACCESS-phase watchdog for apb_master.
// Built only when APB_MASTER_TIMEOUT_EN is defined.
// Ports:
//   PCLK, PRESETn : clock, asynchronous active-low reset
//   in_access     : requester is in the ACCESS state this cycle
//   pready        : APB PREADY
//   timeout       : this ACCESS cycle is the TIMEOUT_CYCLES-th one without
//                   PREADY; the requester ends the transfer at the next edge
module apb_master_wdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic in_access,
  input  logic pready,
  output logic timeout
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  // The count is cleared whenever the FSM is outside ACCESS, so every pass
  // through SETUP starts the next transfer from zero.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q <= '0;
    end else if (!in_access) begin
      cnt_q <= '0;
    end else if (!pready) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // cnt_q holds the waits already seen, so the current cycle is number cnt_q+1.
  assign timeout = in_access && !pready && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_master.sv
// apb_master -- single-outstanding APB requester driven by a valid/ready host port.
// Ports:
//   PCLK, PRESETn : clock (rising edge), asynchronous active-low reset
//   bus           : apb_master_if.master -- host request/response and APB bus
//   dbg_state     : current FSM state, for observation only
// Optional feature: define APB_MASTER_TIMEOUT_EN to end a transfer with
// rsp_err=1 after TIMEOUT_CYCLES ACCESS cycles without PREADY. Without it the
// requester waits indefinitely and rsp_err is always 0.
import apb_pkg::*;

module apb_master #(
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic         PCLK,
  input  logic         PRESETn,
  apb_master_if.master bus,
  output apb_state_e   dbg_state
);

  apb_state_e state_q, state_d;
  logic       done;
  logic       accept;
  logic       timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_master_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .in_access (state_q == ST_ACCESS),
    .pready    (bus.PREADY),
    .timeout   (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
  // The limit only has meaning with the watchdog built in.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_not_applicable
  end
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // A transfer ends on PREADY, or on the watchdog. A timeout ends the
  // transfer exactly like PREADY does, so it also opens the request port.
  always_comb begin
    state_d       = state_q;
    done          = (state_q == ST_ACCESS) && (bus.PREADY || timeout_hit);
    bus.req_ready = (state_q == ST_IDLE) || done;
    accept        = bus.req_valid && bus.req_ready;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (done) state_d = accept ? ST_SETUP : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // APB outputs and response are registered; PREADY/PRDATA only matter via
  // 'done', which is false outside ACCESS.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      bus.PSEL      <= 1'b0;
      bus.PENABLE   <= 1'b0;
      bus.PWRITE    <= 1'b0;
      bus.PADDR     <= '0;
      bus.PWDATA    <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= done;
      bus.rsp_err   <= done && timeout_hit;
      if (done && !timeout_hit && !bus.PWRITE) bus.rsp_rdata <= bus.PRDATA;

      if (accept) begin
        bus.PSEL    <= 1'b1;
        bus.PENABLE <= 1'b0;
        bus.PWRITE  <= bus.req_write;
        bus.PADDR   <= bus.req_addr;
        bus.PWDATA  <= bus.req_wdata;
      end else if (state_q == ST_SETUP) begin
        bus.PENABLE <= 1'b1;
      end else if (done) begin
        bus.PSEL    <= 1'b0;
        bus.PENABLE <= 1'b0;
        bus.PWRITE  <= 1'b0;
        bus.PADDR   <= '0;
        bus.PWDATA  <= '0;
      end
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master -- directed self-checking bench for apb_master.
// Define APB_MASTER_TIMEOUT_EN on both RTL and bench to include the timeout test.
import apb_pkg::*;

module tb_apb_master;

  logic       PCLK;
  logic       PRESETn;
  apb_state_e dbg_state;

  apb_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rd;   // last read data the host should see on rsp_rdata
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    PRESETn = 1'b0;
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'h0;
    #2;
    checks++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b expected 000", {bus.PSEL, bus.PENABLE, bus.PWRITE}); end
    checks++; if ({bus.PADDR, bus.PWDATA} !== 64'h0) begin errors++; $display("FAIL reset_addr_data: got %h expected 0", {bus.PADDR, bus.PWDATA}); end
    checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== 34'h0) begin errors++; $display("FAIL reset_rsp: got %h expected 0", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}); end
    checks++; if (dbg_state !== ST_IDLE || bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_state: state %0d ready %b expected 0 1", dbg_state, bus.req_ready); end
    tick(); tick();
    PRESETn = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    bus.PREADY = 1'b1;
    drive_req(1'b1, 1'b1, 32'h123, 32'hDEADBEEF);
    tick();  // acceptance edge
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);
    checks++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid} !== 4'b1010) begin errors++; $display("FAIL wr_setup_ctrl: got %b expected 1010", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid}); end
    checks++; if (bus.PADDR !== 32'h123 || bus.PWDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_setup_bus: got %h/%h expected 123/deadbeef", bus.PADDR, bus.PWDATA); end
    tick();
    checks++; if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== 3'b110 || bus.PADDR !== 32'h123) begin errors++; $display("FAIL wr_access: got %b addr %h expected 110 addr 123", {bus.PSEL, bus.PENABLE, bus.rsp_valid}, bus.PADDR); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL wr_access_ready: got %b expected 1", bus.req_ready); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL wr_rsp: valid %b err %b expected 1 0", bus.rsp_valid, bus.rsp_err); end
    checks++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b000 || {bus.PADDR, bus.PWDATA} !== 64'h0) begin errors++; $display("FAIL wr_return_zero: got %b %h expected 000 0", {bus.PSEL, bus.PENABLE, bus.PWRITE}, {bus.PADDR, bus.PWDATA}); end
    checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_rdata_unchanged: got %h expected 0", bus.rsp_rdata); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL wr_after: valid %b state %0d expected 0 0", bus.rsp_valid, dbg_state); end
  endtask

  task automatic test_single_read();
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'hFFFF0000;
    drive_req(1'b1, 1'b0, 32'h123, 32'h0);
    tick();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);
    checks++; if (bus.PSEL !== 1'b1 || bus.PWRITE !== 1'b0 || bus.PADDR !== 32'h123) begin errors++; $display("FAIL rd_setup: psel %b pwrite %b addr %h expected 1 0 123", bus.PSEL, bus.PWRITE, bus.PADDR); end
    tick();
    bus.PRDATA = 32'hDEADBEEF;
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEADBEEF || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rd_rsp: valid %b data %h err %b expected 1 deadbeef 0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_err); end
    bus.PRDATA = 32'h55555555;
    tick();
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold: valid %b data %h expected 0 deadbeef", bus.rsp_valid, bus.rsp_rdata); end
  endtask

  task automatic test_wait_states();
    int pen_cnt = 0, pulses = 0, addr_bad = 0, ready_bad = 0;
    logic [31:0] got = 32'h0;
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'h11111111;
    drive_req(1'b1, 1'b0, 32'h456, 32'h0);
    tick();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 12; c++) begin
      if (bus.PENABLE) pen_cnt++;
      if (bus.PSEL && bus.PADDR !== 32'h456) addr_bad++;
      if (bus.rsp_valid) begin pulses++; got = bus.rsp_rdata; end
      // Completer inserts three wait states, then answers in the fourth ACCESS cycle.
      bus.PREADY = (pen_cnt == 4);
      bus.PRDATA = (pen_cnt == 4) ? 32'h0BADF00D : 32'h11111111;
      if (bus.PENABLE && !bus.PREADY && bus.req_ready) ready_bad++;
      tick();
    end
    checks++; if (pen_cnt !== 4) begin errors++; $display("FAIL ws_penable_cycles: got %0d expected 4", pen_cnt); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL ws_rsp_pulses: got %0d expected 1", pulses); end
    checks++; if (addr_bad !== 0) begin errors++; $display("FAIL ws_paddr_stable: got %0d changes expected 0", addr_bad); end
    checks++; if (ready_bad !== 0) begin errors++; $display("FAIL ws_ready_in_wait: got %0d expected 0", ready_bad); end
    checks++; if (got !== 32'h0BADF00D) begin errors++; $display("FAIL ws_rdata: got %h expected 0badf00d", got); end
    last_rd = 32'h0BADF00D;
    bus.PREADY = 1'b1;
  endtask

  task automatic test_back_to_back();
    int issued = 0, rsp_cnt = 0, gaps = 0, ticks = 0;
    logic acc;
    logic [31:0] e;
    exp_q.delete();
    // Even items read, odd items write; writes leave rsp_rdata at the last read.
    for (int i = 0; i < 10; i++) begin
      logic [31:0] a;
      a = 32'h100 + 32'(i) * 4;
      if (i % 2 == 0) last_rd = {16'hC0DE, a[15:0]};
      exp_q.push_back(last_rd);
    end
    bus.PREADY = 1'b1;
    drive_req(1'b1, 1'b0, 32'h100, 32'h50000000);
    for (int cyc = 0; cyc < 60 && rsp_cnt < 10; cyc++) begin
      // Completer returns data derived from the address it is presented.
      bus.PRDATA = {16'hC0DE, bus.PADDR[15:0]};
      if (issued > 0 && issued < 10 && (!bus.PSEL || dbg_state == ST_IDLE)) gaps++;
      acc = bus.req_valid && bus.req_ready;
      tick();
      if (issued > 0) ticks++;
      if (acc) begin
        issued++;
        if (issued < 10) drive_req(1'b1, (issued % 2) == 1, 32'h100 + 32'(issued) * 4, 32'h50000000 + 32'(issued));
        else drive_req(1'b0, 1'b0, 32'h0, 32'h0);
      end
      if (bus.rsp_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXXXXXX;
        checks++; if (bus.rsp_rdata !== e || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL b2b_rsp%0d: data %h err %b expected %h 0", rsp_cnt, bus.rsp_rdata, bus.rsp_err, e); end
        rsp_cnt++;
      end
    end
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);
    checks++; if (rsp_cnt !== 10) begin errors++; $display("FAIL b2b_rsp_count: got %0d expected 10", rsp_cnt); end
    checks++; if (gaps !== 0) begin errors++; $display("FAIL b2b_no_idle: got %0d gap cycles expected 0", gaps); end
    checks++; if (ticks !== 20) begin errors++; $display("FAIL b2b_cycles: got %0d expected 20", ticks); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0 || bus.PSEL !== 1'b0) begin errors++; $display("FAIL b2b_end_idle: valid %b psel %b expected 0 0", bus.rsp_valid, bus.PSEL); end
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int acc_cnt = 0;
    logic seen = 1'b0;
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'hAAAA5555;
    drive_req(1'b1, 1'b0, 32'h200, 32'h0);
    tick();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 40 && !seen; c++) begin
      if (bus.rsp_valid) seen = 1'b1;
      else begin
        if (bus.PENABLE) acc_cnt++;
        tick();
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL to_no_rsp: got no rsp_valid expected one within 40 cycles"); end
    checks++; if (acc_cnt !== 16) begin errors++; $display("FAIL to_access_cycles: got %0d expected 16", acc_cnt); end
    checks++; if (bus.rsp_err !== 1'b1 || bus.rsp_rdata !== last_rd) begin errors++; $display("FAIL to_rsp: err %b data %h expected 1 %h", bus.rsp_err, bus.rsp_rdata, last_rd); end
    checks++; if (dbg_state !== ST_IDLE || bus.PSEL !== 1'b0) begin errors++; $display("FAIL to_idle: state %0d psel %b expected 0 0", dbg_state, bus.PSEL); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL to_after: valid %b err %b expected 0 0", bus.rsp_valid, bus.rsp_err); end
    bus.PREADY = 1'b1;
  endtask
`endif

  task automatic test_reset_mid();
    int pulses = 0;
    bus.PREADY = 1'b0;
    drive_req(1'b1, 1'b1, 32'h300, 32'hCAFEF00D);
    tick();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checks++; if (bus.PENABLE !== 1'b1 || dbg_state !== ST_ACCESS) begin errors++; $display("FAIL rm_in_access: penable %b state %0d expected 1 2", bus.PENABLE, dbg_state); end
    tick(); tick();
    #2;
    PRESETn = 1'b0;
    #1;
    checks++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err} !== 5'b0) begin errors++; $display("FAIL rm_ctrl_zero: got %b expected 00000", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err}); end
    checks++; if ({bus.PADDR, bus.PWDATA, bus.rsp_rdata} !== 96'h0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL rm_data_zero: got %h state %0d expected 0 0", {bus.PADDR, bus.PWDATA, bus.rsp_rdata}, dbg_state); end
    bus.PREADY = 1'b1;
    @(negedge PCLK);
    PRESETn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.rsp_valid) pulses++;
    end
    checks++; if (pulses !== 0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL rm_dropped: pulses %0d state %0d expected 0 0", pulses, dbg_state); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_wait_states();
    test_back_to_back();
`ifdef APB_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
